// File: rtl/softex_pkg.sv
// Shared types for the SoftEx strobe generators: transfer configuration, FSM states, widths.
package softex_pkg;

    localparam int DATA_W     = 256;
    localparam int STRB_CNT_W = 16;
    localparam int STRB_NB    = DATA_W / 8;
    localparam int STRB_OFF_W = $clog2(STRB_NB);

    typedef struct packed {
        logic [STRB_CNT_W-1:0] line_bytes;
        logic [STRB_CNT_W-1:0] n_lines;
        logic [STRB_OFF_W-1:0] offset;
    } softex_strb_cfg_t;

    typedef enum logic {
        STRB_IDLE,
        STRB_RUN
    } softex_strb_state_e;

endpackage

// File: rtl/softex_strb_mask_gen.sv
// Combinational byte-strobe mask for one beat of a line: masks lanes below the offset on the
// first beat and lanes past the end index on the last beat (both on a single-beat line).
module softex_strb_mask_gen
    import softex_pkg::*;
#(
    parameter int NB    = STRB_NB,
    parameter int OFF_W = $clog2(NB)
) (
    input  logic [OFF_W-1:0] i_offset,
    input  logic [OFF_W-1:0] i_end_idx,
    input  logic             i_first,
    input  logic             i_last,
    output logic [NB-1:0]    o_strb
);

    always_comb begin
        o_strb = '0;
        for (int i = 0; i < NB; i++) begin
            o_strb[i] = (!i_first || (OFF_W'(i) >= i_offset)) &&
                        (!i_last  || (OFF_W'(i) <= i_end_idx));
        end
    end

endmodule

// File: rtl/softex_streamer_strb_gen_nd.sv
// Per-beat byte-strobe generator for 2-D (n_lines x line_bytes) streamer transfers with a start offset.
// Optional build macro SOFTEX_STRB_ZERO_DATA_EN zeroes the data bytes whose strobe is low.
module softex_streamer_strb_gen_nd
    import softex_pkg::*;
#(
    parameter int DW    = DATA_W,
    parameter int CNT_W = STRB_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             start_i,
    input  softex_strb_cfg_t cfg_i,
    output logic             busy_o,
    output logic             done_o,
    input  logic             stream_i_valid,
    output logic             stream_i_ready,
    input  logic [DW-1:0]    stream_i_data,
    output logic             stream_o_valid,
    input  logic             stream_o_ready,
    output logic [DW-1:0]    stream_o_data,
    output logic [DW/8-1:0]  stream_o_strb
);

    localparam int NB    = DW / 8;
    localparam int OFF_W = $clog2(NB);

    softex_strb_state_e r_state;
    logic [CNT_W-1:0]   r_beat;
    logic [CNT_W-1:0]   r_line;
    logic               r_busy;
    logic               r_done;

    logic [CNT_W:0]     r_bpl;
    logic [CNT_W-1:0]   r_nl_m1;
    logic [OFF_W-1:0]   r_off;
    logic [OFF_W-1:0]   r_end;

    logic [CNT_W:0]     w_len;
    logic               w_degen;
    logic               w_run;
    logic               w_hs;
    logic               w_first;
    logic               w_last;
    logic               w_last_line;
    logic [NB-1:0]      w_mask;

    // Lane span of one line including the offset; one extra bit keeps the ceiling division exact.
    assign w_len   = {1'b0, cfg_i.line_bytes} + (CNT_W+1)'(cfg_i.offset);
    assign w_degen = (cfg_i.line_bytes == '0) || (cfg_i.n_lines == '0);

    always_ff @(posedge clk_i) begin
        if (r_state == STRB_IDLE && start_i) begin
            r_bpl   <= (w_len + (CNT_W+1)'(NB-1)) >> OFF_W;
            r_nl_m1 <= cfg_i.n_lines - CNT_W'(1);
            r_off   <= OFF_W'(cfg_i.offset);
            r_end   <= OFF_W'(w_len - (CNT_W+1)'(1));
        end
    end

    assign w_run       = (r_state == STRB_RUN);
    assign w_hs        = w_run & stream_i_valid & stream_o_ready;
    assign w_first     = (r_beat == '0);
    assign w_last      = ({1'b0, r_beat} == (r_bpl - (CNT_W+1)'(1)));
    assign w_last_line = (r_line == r_nl_m1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= STRB_IDLE;
            r_beat  <= '0;
            r_line  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else if (clear_i) begin
            r_state <= STRB_IDLE;
            r_beat  <= '0;
            r_line  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                STRB_IDLE: begin
                    if (start_i) begin
                        if (w_degen) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state <= STRB_RUN;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                STRB_RUN: begin
                    if (w_hs) begin
                        if (!w_last) begin
                            r_beat <= r_beat + CNT_W'(1);
                        end else begin
                            r_beat <= '0;
                            if (w_last_line) begin
                                r_line  <= '0;
                                r_state <= STRB_IDLE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end else begin
                                r_line <= r_line + CNT_W'(1);
                            end
                        end
                    end
                end
                default: r_state <= STRB_IDLE;
            endcase
        end
    end

    softex_strb_mask_gen #(
        .NB    (NB),
        .OFF_W (OFF_W)
    ) i_mask_gen (
        .i_offset  (r_off),
        .i_end_idx (r_end),
        .i_first   (w_first),
        .i_last    (w_last),
        .o_strb    (w_mask)
    );

    assign busy_o         = r_busy;
    assign done_o         = r_done;
    assign stream_o_valid = w_run & stream_i_valid;
    assign stream_i_ready = w_run & stream_o_ready;
    assign stream_o_strb  = w_run ? w_mask : '0;

`ifdef SOFTEX_STRB_ZERO_DATA_EN
    always_comb begin
        stream_o_data = '0;
        for (int i = 0; i < NB; i++) begin
            stream_o_data[8*i +: 8] = stream_o_strb[i] ? stream_i_data[8*i +: 8] : 8'h00;
        end
    end
`else
    assign stream_o_data = stream_i_data;
`endif

endmodule

// File: tb/tb_softex_streamer_strb_gen_nd.sv
// Randomised self-checking bench for softex_streamer_strb_gen_nd against a lane-arithmetic model.
module tb_softex_streamer_strb_gen_nd;
    import softex_pkg::*;

    localparam int DW = 256;
    localparam int NB = 32;
`ifdef SOFTEX_STRB_ZERO_DATA_EN
    localparam bit ZERO_EN = 1'b1;
`else
    localparam bit ZERO_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_ni = 1'b0;
    logic             clear_i = 1'b0;
    logic             start_i = 1'b0;
    softex_strb_cfg_t cfg_i = '0;
    logic             busy_o, done_o;
    logic             stream_i_valid = 1'b0;
    logic             stream_i_ready;
    logic [DW-1:0]    stream_i_data = '0;
    logic             stream_o_valid;
    logic             stream_o_ready = 1'b0;
    logic [DW-1:0]    stream_o_data;
    logic [NB-1:0]    stream_o_strb;

    always #5 clk = ~clk;

    softex_streamer_strb_gen_nd #(.DW(DW), .CNT_W(16)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .clear_i        (clear_i),
        .start_i        (start_i),
        .cfg_i          (cfg_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .stream_i_valid (stream_i_valid),
        .stream_i_ready (stream_i_ready),
        .stream_i_data  (stream_i_data),
        .stream_o_valid (stream_o_valid),
        .stream_o_ready (stream_o_ready),
        .stream_o_data  (stream_o_data),
        .stream_o_strb  (stream_o_strb)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk_b(string name, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0b required=%0b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_s(string name, logic [NB-1:0] act, logic [NB-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%08h required=%08h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_d(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_i(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: a line occupies lanes [off, off+lb) of a flat lane space cut into NB-lane beats.
    function automatic logic [NB-1:0] exp_strb(int off, int lb, int b);
        logic [NB-1:0] s;
        for (int i = 0; i < NB; i++) begin
            int lane;
            lane = b * NB + i;
            s[i] = (lane >= off) && (lane < off + lb);
        end
        return s;
    endfunction

    function automatic logic [DW-1:0] exp_data(logic [DW-1:0] d, logic [NB-1:0] s);
        logic [DW-1:0] r;
        for (int i = 0; i < NB; i++)
            r[8*i +: 8] = (s[i] || !ZERO_EN) ? d[8*i +: 8] : 8'h00;
        return r;
    endfunction

    bit            m_busy = 1'b0;
    bit            m_done = 1'b0;
    logic [NB-1:0] exp_q[$];
    logic [NB-1:0] log_strb[$];
    logic [DW-1:0] log_data[$];

    task automatic push_xfer(int off, int lb, int nl);
        int bpl;
        bpl = (off + lb + NB - 1) / NB;
        for (int l = 0; l < nl; l++)
            for (int b = 0; b < bpl; b++)
                exp_q.push_back(exp_strb(off, lb, b));
    endtask

    // Compare process: every falling edge, outputs vs model, then advance the model.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_ni) begin
                chk_b("rst_busy", busy_o, 1'b0);
                chk_b("rst_done", done_o, 1'b0);
                chk_b("rst_o_valid", stream_o_valid, 1'b0);
                chk_b("rst_i_ready", stream_i_ready, 1'b0);
                m_busy = 1'b0;
                m_done = 1'b0;
                exp_q.delete();
            end else begin
                bit nb, nd;
                chk_b("done", done_o, m_done);
                chk_b("busy", busy_o, m_busy);
                chk_b("o_valid", stream_o_valid, m_busy & stream_i_valid);
                chk_b("i_ready", stream_i_ready, m_busy & stream_o_ready);
                nb = m_busy;
                nd = 1'b0;
                if (m_busy && stream_i_valid) begin
                    if (exp_q.size() == 0) begin
                        chk_b("beat_extra", 1'b1, 1'b0);
                    end else begin
                        chk_s("strb", stream_o_strb, exp_q[0]);
                        chk_b("strb_nonzero", stream_o_strb != '0, 1'b1);
                        chk_d("data", stream_o_data, exp_data(stream_i_data, exp_q[0]));
                    end
                end
                if (clear_i) begin
                    nb = 1'b0;
                    exp_q.delete();
                end else if (m_busy) begin
                    if (stream_i_valid && stream_o_ready && exp_q.size() > 0) begin
                        log_strb.push_back(stream_o_strb);
                        log_data.push_back(stream_o_data);
                        void'(exp_q.pop_front());
                        if (exp_q.size() == 0) begin
                            nb = 1'b0;
                            nd = 1'b1;
                        end
                    end
                end else if (start_i) begin
                    if (cfg_i.line_bytes == 0 || cfg_i.n_lines == 0) begin
                        nd = 1'b1;
                    end else begin
                        push_xfer(int'(cfg_i.offset), int'(cfg_i.line_bytes), int'(cfg_i.n_lines));
                        nb = 1'b1;
                    end
                end
                m_busy = nb;
                m_done = nd;
            end
        end
    end

    task automatic drive_beat(bit bp);
        stream_i_valid = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
        stream_o_ready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
        for (int k = 0; k < DW / 32; k++)
            stream_i_data[32*k +: 32] = $urandom;
    endtask

    task automatic start_xfer(int off, int lb, int nl);
        log_strb.delete();
        log_data.delete();
        cfg_i.offset     = STRB_OFF_W'(off);
        cfg_i.line_bytes = 16'(lb);
        cfg_i.n_lines    = 16'(nl);
        stream_i_valid   = 1'b0;
        start_i          = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    task automatic xfer(int off, int lb, int nl, bit bp);
        int cyc;
        start_xfer(off, lb, nl);
        cyc = 0;
        while (m_busy && cyc < 4000) begin
            drive_beat(bp);
            cfg_i = softex_strb_cfg_t'($urandom);
            @(posedge clk); #1;
            cyc++;
        end
        if (m_busy) chk_i("xfer_timeout", cyc, -1);
        stream_i_valid = 1'b0;
        stream_o_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_ni = 1'b1;
        @(posedge clk); #1;

        // 1: aligned, two full-width lines
        xfer(0, 64, 2, 1'b0);
        chk_i("s1_beats", log_strb.size(), 4);
        chk_s("s1_b0", log_strb[0], 32'hFFFFFFFF);
        chk_s("s1_b3", log_strb[3], 32'hFFFFFFFF);

        // 2: offset 4, 40 bytes
        xfer(4, 40, 1, 1'b0);
        chk_i("s2_beats", log_strb.size(), 2);
        chk_s("s2_b0", log_strb[0], 32'hFFFFFFF0);
        chk_s("s2_b1", log_strb[1], 32'h00000FFF);
        if (ZERO_EN) chk_d("s2_zero_lo", {224'h0, log_data[0][31:0]}, '0);

        // 3: single-beat lines, both masks
        xfer(8, 8, 3, 1'b0);
        chk_i("s3_beats", log_strb.size(), 3);
        for (int k = 0; k < 3; k++) chk_s("s3_b", log_strb[k], 32'h0000FF00);

        // 4: degenerate configurations
        xfer(0, 0, 3, 1'b0);
        chk_i("s4_beats", log_strb.size(), 0);
        xfer(5, 20, 0, 1'b0);
        chk_i("s4b_beats", log_strb.size(), 0);

        // 5: backpressure, five lines
        xfer(4, 40, 5, 1'b1);
        chk_i("s5_beats", log_strb.size(), 10);
        for (int k = 0; k < 10; k++)
            chk_s("s5_b", log_strb[k], (k % 2 == 0) ? 32'hFFFFFFF0 : 32'h00000FFF);

        // 6: clear after one handshake, then replay
        start_xfer(0, 64, 2);
        stream_i_valid = 1'b1;
        stream_o_ready = 1'b1;
        @(posedge clk); #1;
        clear_i = 1'b1;
        @(posedge clk); #1;
        clear_i = 1'b0;
        stream_i_valid = 1'b0;
        chk_i("s6_hs_before_clear", log_strb.size(), 1);
        @(posedge clk); #1;
        xfer(0, 64, 2, 1'b0);
        chk_i("s6_replay_beats", log_strb.size(), 4);
        chk_s("s6_replay_b0", log_strb[0], 32'hFFFFFFFF);

        // Random transfers under backpressure
        for (int t = 0; t < 12; t++)
            xfer($urandom_range(0, NB - 1), $urandom_range(1, 100), $urandom_range(1, 4), 1'b1);

        // Asynchronous reset mid-transfer
        start_xfer(3, 90, 3);
        for (int k = 0; k < 3; k++) begin
            drive_beat(1'b0);
            @(posedge clk); #1;
        end
        rst_ni = 1'b0;
        @(posedge clk); #1;
        rst_ni = 1'b1;
        stream_i_valid = 1'b0;
        @(posedge clk); #1;
        xfer(31, 1, 2, 1'b1);
        chk_i("post_rst_beats", log_strb.size(), 2);
        chk_s("post_rst_b0", log_strb[0], 32'h80000000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
